mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Stage directly downstream of the execute stage. It owns the EX/MEM register and a single-outstanding load/store FSM on a req/ack data bus.
- It performs MIPS byte/half/word lane steering and the load extension.
- It feeds the write-back stage through a registered MEM/WB output.
- It exports its held HI/LO write to the execute stage for forwarding, and raises a stall request while a bus access is pending.

Parameters:
- BIG_ENDIAN, 1, byte lane order. 1: address offset 0 maps to bits [31:24]. 0: offset 0 maps to bits [7:0].

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- ex_wd_i  in  5  destination register from execute
- ex_wreg_i  in  1  register write enable from execute
- ex_wdata_i  in  32  ALU result from execute
- ex_hi_i, ex_lo_i  in  32 each  HI/LO values from execute
- ex_whilo_i  in  1  HI/LO write enable from execute
- ex_aluop_i  in  8  operation code (`AluOpBus`)
- ex_mem_addr_i  in  32  effective address
- ex_store_data_i  in  32  store source register
- dbus_req_o  out  1  bus request, held until ack
- dbus_we_o  out  1  1 = store
- dbus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dbus_sel_o  out  4  byte enables
- dbus_wdata_o  out  32  lane-replicated store data
- dbus_ack_i  in  1  access complete, sampled at the clock edge
- dbus_rdata_i  in  32  load data, valid with ack
- stallreq_o  out  1  combinational; upstream must hold its outputs
- fwd_hi_o, fwd_lo_o  out  32 each  HI/LO held in the EX/MEM register
- fwd_whilo_o  out  1  HI/LO write enable held in the EX/MEM register
- wb_wd_o, wb_wreg_o, wb_wdata_o  out  5/1/32  registered MEM/WB register write
- wb_hi_o, wb_lo_o, wb_whilo_o  out  32/32/1  registered MEM/WB HI/LO write
- misalign_o  out  1  registered one-cycle pulse aligned with wb_* outputs
- badaddr_o  out  32  faulting address, valid while misalign_o = 1

Behaviour:
- Reset (synchronous): all outputs and internal registers become 0; state = IDLE.
- Reset mid-access drops dbus_req_o at that edge. The access is abandoned.
- EX/MEM register S = {valid, aluop, wd, wreg, wdata, hi, lo, whilo, addr, sdata}.
  - S captures ex_* at every edge where stallreq_o = 0.
  - S holds while stallreq_o = 1.
- States:
  - IDLE: S empty or holds a non-memory op.
  - BUS: a memory op is outstanding.
- Transitions:
  - A memory op captured and aligned → BUS. dbus_req_o goes to 1 at the same edge; all dbus_* outputs are registered.
  - In BUS with dbus_ack_i = 1 → the op completes at that edge. dbus_req_o goes to 0, unless the op captured at that edge is itself a memory op, in which case req stays 1 with the new address/sel/wdata (back-to-back).
  - In BUS with ack = 0 → stay in BUS.
- stallreq_o = (state == BUS) & ~dbus_ack_i.
- MEM/WB update at each edge:
  - Non-memory S: wb_* ← S fields; latency of 2 edges from ex outputs to wb outputs.
  - Memory S on ack: wb_* ← S fields, with wdata replaced by extended load data for loads. Stores force wb_wreg_o = 0.
  - Stalled cycle: bubble, i.e. wb_wreg_o = 0 and wb_whilo_o = 0.
- Zero-wait ack (ack high in the first req cycle) → no stall cycle.
- fwd_whilo_o = S.valid & S.whilo. fwd_hi_o / fwd_lo_o = S.hi / S.lo.
- Lane rules (BIG_ENDIAN = 1):
  - Byte at offset k uses sel bit (3-k).
  - Halfword: offset 0 → 4'b1100; offset 2 → 4'b0011.
  - Word → 4'b1111.
  - SB wdata = {4{b}}; SH wdata = {2{h}}.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Alignment:
  - Halfword with addr[0] = 1, or word with addr[1:0] ≠ 0, is misaligned.
  - A misaligned op issues no request and completes at the next edge with wb_wreg_o = 0, misalign_o = 1, badaddr_o = addr.
- Unknown aluop is treated as a non-memory op.

Decomposition:
- define.v gains `EXE_LB_OP`, `EXE_LBU_OP`, `EXE_LH_OP`, `EXE_LHU_OP`, `EXE_LW_OP`, `EXE_SB_OP`, `EXE_SH_OP`, `EXE_SW_OP`, plus `ByteSelBus` 3:0.
- Sub-module mem_lane_steer (combinational): takes aluop and addr[1:0] and produces sel, store wdata, load extract/extend, and misaligned.

Test Plan:
- ex OR result 32'h0000_F0F0, wd = 3, wreg = 1 → wb_wdata_o = 32'h0000_F0F0, wb_wd_o = 3 two edges later; dbus_req_o stays 0.
- SW addr 32'h100, data 32'hDEADBEEF, ack held 3 cycles → stallreq_o = 1 for 2 cycles; sel = 4'hF, addr = 32'h100; wb_wreg_o = 0; bubbles emitted while stalled.
- LB addr 32'h103, rdata 32'h0000_0080, zero-wait ack → wb_wdata_o = 32'hFFFF_FF80, sel = 4'b0001; no stall. Same access with LBU → 32'h0000_0080.
- SH addr 32'h202, data 32'h1234_ABCD → sel = 4'b0011, wdata = 32'hABCD_ABCD. LH addr 32'h201 → no req, misalign_o = 1, badaddr_o = 32'h201, wb_wreg_o = 0.
- MTHI 32'h55 followed by a load stalled 2 cycles → fwd_whilo_o = 1 with fwd_hi_o = 32'h55 while MTHI is in S; wb_whilo_o pulses once; back-to-back LW keeps dbus_req_o high across the ack edge.
- rst asserted in BUS mid-wait → next edge dbus_req_o = 0, all wb_* = 0, state IDLE; a following LW proceeds normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_pkg : opcodes, EX/MEM record and FSM states for mem_stage      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_stage_pkg;

   localparam int ALU_OP_W   = 8;
   localparam int BYTE_SEL_W = 4;

   localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic                valid;
      logic [ALU_OP_W-1:0] aluop;
      logic [4:0]          wd;
      logic                wreg;
      logic [31:0]         wdata;
      logic [31:0]         hi;
      logic [31:0]         lo;
      logic                whilo;
      logic [31:0]         addr;
      logic [31:0]         sdata;
   } exmem_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_steer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lane_steer : byte-lane select, store replication, load extend/align  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_lane_steer
   import mem_stage_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic [ALU_OP_W-1:0]   aluop,
   input  logic [1:0]            offset,
   input  logic [31:0]           store_data,
   input  logic [31:0]           rdata,
   output logic                  is_mem,
   output logic                  is_store,
   output logic                  misaligned,
   output logic [BYTE_SEL_W-1:0] sel,
   output logic [31:0]           wdata,
   output logic [31:0]           load_data
);

   logic [1:0]  w_byte_lane;
   logic        w_half_hi;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Big-endian puts offset 0 in the top lane, so the lane index is 3-offset.
   assign w_byte_lane = BIG_ENDIAN ? ~offset : offset;
   assign w_half_hi   = BIG_ENDIAN ? ~offset[1] : offset[1];
   assign w_byte      = rdata[{w_byte_lane, 3'b000} +: 8];
   assign w_half      = w_half_hi ? rdata[31:16] : rdata[15:0];

   always_comb begin
      is_mem     = 1'b0;
      is_store   = 1'b0;
      misaligned = 1'b0;
      sel        = '0;
      wdata      = '0;
      load_data  = '0;
      case (aluop)
         EXE_LB_OP, EXE_LBU_OP: begin
            is_mem    = 1'b1;
            sel       = 4'b0001 << w_byte_lane;
            load_data = {{24{w_byte[7] & (aluop == EXE_LB_OP)}}, w_byte};
         end
         EXE_LH_OP, EXE_LHU_OP: begin
            is_mem     = 1'b1;
            misaligned = offset[0];
            sel        = w_half_hi ? 4'b1100 : 4'b0011;
            load_data  = {{16{w_half[15] & (aluop == EXE_LH_OP)}}, w_half};
         end
         EXE_LW_OP: begin
            is_mem     = 1'b1;
            misaligned = |offset;
            sel        = 4'b1111;
            load_data  = rdata;
         end
         EXE_SB_OP: begin
            is_mem   = 1'b1;
            is_store = 1'b1;
            sel      = 4'b0001 << w_byte_lane;
            wdata    = {4{store_data[7:0]}};
         end
         EXE_SH_OP: begin
            is_mem     = 1'b1;
            is_store   = 1'b1;
            misaligned = offset[0];
            sel        = w_half_hi ? 4'b1100 : 4'b0011;
            wdata      = {2{store_data[15:0]}};
         end
         EXE_SW_OP: begin
            is_mem     = 1'b1;
            is_store   = 1'b1;
            misaligned = |offset;
            sel        = 4'b1111;
            wdata      = store_data;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage : EX/MEM register, single-outstanding data-bus FSM, MEM/WB reg |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4:0]            ex_wd_i,
   input  logic                  ex_wreg_i,
   input  logic [31:0]           ex_wdata_i,
   input  logic [31:0]           ex_hi_i,
   input  logic [31:0]           ex_lo_i,
   input  logic                  ex_whilo_i,
   input  logic [ALU_OP_W-1:0]   ex_aluop_i,
   input  logic [31:0]           ex_mem_addr_i,
   input  logic [31:0]           ex_store_data_i,
   output logic                  dbus_req_o,
   output logic                  dbus_we_o,
   output logic [31:0]           dbus_addr_o,
   output logic [BYTE_SEL_W-1:0] dbus_sel_o,
   output logic [31:0]           dbus_wdata_o,
   input  logic                  dbus_ack_i,
   input  logic [31:0]           dbus_rdata_i,
   output logic                  stallreq_o,
   output logic [31:0]           fwd_hi_o,
   output logic [31:0]           fwd_lo_o,
   output logic                  fwd_whilo_o,
   output logic [4:0]            wb_wd_o,
   output logic                  wb_wreg_o,
   output logic [31:0]           wb_wdata_o,
   output logic [31:0]           wb_hi_o,
   output logic [31:0]           wb_lo_o,
   output logic                  wb_whilo_o,
   output logic                  misalign_o,
   output logic [31:0]           badaddr_o
);

   mem_state_e              r_state;
   mem_state_e              w_state_nxt;
   exmem_t                  r_s;
   exmem_t                  w_ex;
   logic                    w_capture;
   logic                    w_issue;

   logic                    w_iss_is_mem, w_iss_is_store, w_iss_mis;
   logic [BYTE_SEL_W-1:0]   w_iss_sel;
   logic [31:0]             w_iss_wdata, w_iss_load;
   logic                    w_rsp_is_mem, w_rsp_is_store, w_rsp_mis;
   logic [BYTE_SEL_W-1:0]   w_rsp_sel;
   logic [31:0]             w_rsp_wdata, w_rsp_load;
   logic                    w_unused_ok;

   logic [4:0]              w_wb_wd;
   logic                    w_wb_wreg, w_wb_whilo, w_wb_mis;
   logic [31:0]             w_wb_wdata, w_wb_hi, w_wb_lo, w_wb_badaddr;

   assign w_ex = '{valid: 1'b1, aluop: ex_aluop_i, wd: ex_wd_i, wreg: ex_wreg_i,
                   wdata: ex_wdata_i, hi: ex_hi_i, lo: ex_lo_i, whilo: ex_whilo_i,
                   addr: ex_mem_addr_i, sdata: ex_store_data_i};

   // Issue side decodes the incoming op so the request launches on its capture edge.
   mem_lane_steer #(.BIG_ENDIAN(BIG_ENDIAN)) u_issue (
      .aluop      (ex_aluop_i),
      .offset     (ex_mem_addr_i[1:0]),
      .store_data (ex_store_data_i),
      .rdata      (dbus_rdata_i),
      .is_mem     (w_iss_is_mem),
      .is_store   (w_iss_is_store),
      .misaligned (w_iss_mis),
      .sel        (w_iss_sel),
      .wdata      (w_iss_wdata),
      .load_data  (w_iss_load)
   );

   // Response side decodes the held op for load extraction and write-back.
   mem_lane_steer #(.BIG_ENDIAN(BIG_ENDIAN)) u_resp (
      .aluop      (r_s.aluop),
      .offset     (r_s.addr[1:0]),
      .store_data (r_s.sdata),
      .rdata      (dbus_rdata_i),
      .is_mem     (w_rsp_is_mem),
      .is_store   (w_rsp_is_store),
      .misaligned (w_rsp_mis),
      .sel        (w_rsp_sel),
      .wdata      (w_rsp_wdata),
      .load_data  (w_rsp_load)
   );

   assign w_unused_ok = ^{w_iss_load, w_rsp_is_mem, w_rsp_sel, w_rsp_wdata};

   assign stallreq_o  = (r_state == ST_BUS) & ~dbus_ack_i;
   assign w_capture   = ~stallreq_o;
   assign w_issue     = w_iss_is_mem & ~w_iss_mis;

   assign fwd_whilo_o = r_s.valid & r_s.whilo;
   assign fwd_hi_o    = r_s.hi;
   assign fwd_lo_o    = r_s.lo;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_wb_wd      = '0;
      w_wb_wreg    = 1'b0;
      w_wb_wdata   = '0;
      w_wb_hi      = '0;
      w_wb_lo      = '0;
      w_wb_whilo   = 1'b0;
      w_wb_mis     = 1'b0;
      w_wb_badaddr = '0;

      if (w_capture) w_state_nxt = w_issue ? ST_BUS : ST_IDLE;

      if (r_state == ST_BUS) begin
         // Outstanding access: retire on ack, otherwise emit a bubble.
         if (dbus_ack_i) begin
            w_wb_wd    = r_s.wd;
            w_wb_wreg  = r_s.wreg & ~w_rsp_is_store;
            w_wb_wdata = w_rsp_is_store ? r_s.wdata : w_rsp_load;
            w_wb_hi    = r_s.hi;
            w_wb_lo    = r_s.lo;
            w_wb_whilo = r_s.whilo;
         end
      end else if (r_s.valid) begin
         w_wb_wd      = r_s.wd;
         w_wb_wreg    = r_s.wreg & ~w_rsp_mis;
         w_wb_wdata   = r_s.wdata;
         w_wb_hi      = r_s.hi;
         w_wb_lo      = r_s.lo;
         w_wb_whilo   = r_s.whilo;
         w_wb_mis     = w_rsp_mis;
         w_wb_badaddr = w_rsp_mis ? r_s.addr : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s          <= '0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_sel_o   <= '0;
         dbus_wdata_o <= '0;
         wb_wd_o      <= '0;
         wb_wreg_o    <= 1'b0;
         wb_wdata_o   <= '0;
         wb_hi_o      <= '0;
         wb_lo_o      <= '0;
         wb_whilo_o   <= 1'b0;
         misalign_o   <= 1'b0;
         badaddr_o    <= '0;
      end else begin
         wb_wd_o      <= w_wb_wd;
         wb_wreg_o    <= w_wb_wreg;
         wb_wdata_o   <= w_wb_wdata;
         wb_hi_o      <= w_wb_hi;
         wb_lo_o      <= w_wb_lo;
         wb_whilo_o   <= w_wb_whilo;
         misalign_o   <= w_wb_mis;
         badaddr_o    <= w_wb_badaddr;
         if (w_capture) begin
            r_s          <= w_ex;
            dbus_req_o   <= w_issue;
            dbus_we_o    <= w_issue & w_iss_is_store;
            dbus_addr_o  <= w_issue ? {ex_mem_addr_i[31:2], 2'b00} : 32'h0;
            dbus_sel_o   <= w_issue ? w_iss_sel : '0;
            dbus_wdata_o <= w_issue ? w_iss_wdata : 32'h0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_stage : scoreboard bench with directed and random op streams      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_OR    = 8'b0010_0101;
   localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
   localparam logic [7:0] OP_BOGUS = 8'hC7;

   typedef struct {
      logic [7:0]  aluop;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata, hi, lo;
      logic        whilo;
      logic [31:0] addr, sdata;
      int          delay;
   } instr_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      int          delay;
   } bus_t;

   typedef struct packed {
      logic        wreg;
      logic [4:0]  wd;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi, lo;
      logic        mis;
      logic [31:0] badaddr;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  ex_wd_i;
   logic        ex_wreg_i, ex_whilo_i;
   logic [31:0] ex_wdata_i, ex_hi_i, ex_lo_i, ex_mem_addr_i, ex_store_data_i;
   logic [7:0]  ex_aluop_i;
   logic        dbus_req_o, dbus_we_o, dbus_ack_i;
   logic [31:0] dbus_addr_o, dbus_wdata_o, dbus_rdata_i;
   logic [3:0]  dbus_sel_o;
   logic        stallreq_o, fwd_whilo_o, wb_wreg_o, wb_whilo_o, misalign_o;
   logic [31:0] fwd_hi_o, fwd_lo_o, wb_wdata_o, wb_hi_o, wb_lo_o, badaddr_o;
   logic [4:0]  wb_wd_o;

   int total = 0;
   int bad = 0;
   int stall_cnt = 0;
   int stall_exp = 0;
   bit checking = 1'b0;
   bus_t   bus_q[$];
   ev_t    ev_q[$];
   instr_t s_model;
   logic [31:0] mem_over[logic [31:0]];

   always #5 clk = ~clk;

   mem_stage #(.BIG_ENDIAN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .ex_wd_i(ex_wd_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
      .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .ex_whilo_i(ex_whilo_i),
      .ex_aluop_i(ex_aluop_i), .ex_mem_addr_i(ex_mem_addr_i),
      .ex_store_data_i(ex_store_data_i),
      .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
      .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
      .stallreq_o(stallreq_o), .fwd_hi_o(fwd_hi_o), .fwd_lo_o(fwd_lo_o),
      .fwd_whilo_o(fwd_whilo_o), .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o),
      .wb_wdata_o(wb_wdata_o), .wb_hi_o(wb_hi_o), .wb_lo_o(wb_lo_o),
      .wb_whilo_o(wb_whilo_o), .misalign_o(misalign_o), .badaddr_o(badaddr_o)
   );

   // Read-only memory image: a scrambled function of the address unless overridden.
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (mem_over.exists(a)) return mem_over[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic instr_t mk(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                                 input logic [31:0] wdata, input logic whilo, input logic [31:0] hi,
                                 input logic [31:0] addr, input logic [31:0] sdata, input int delay);
      instr_t r;
      r.aluop = op; r.wd = wd; r.wreg = wreg; r.wdata = wdata; r.whilo = whilo;
      r.hi = hi; r.lo = 32'h0; r.addr = addr; r.sdata = sdata; r.delay = delay;
      return r;
   endfunction

   // Reference model: derive bus transfer and write-back result from the op's meaning.
   task automatic predict(input instr_t in);
      int sz, off;
      bit ld, st, sgn, mis;
      logic [31:0] word, val;
      bus_t bt;
      ev_t ev;
      sz = 0; ld = 0; st = 0; sgn = 0; val = 32'h0;
      case (in.aluop)
         EXE_LB_OP:  begin sz = 1; ld = 1; sgn = 1; end
         EXE_LBU_OP: begin sz = 1; ld = 1; end
         EXE_LH_OP:  begin sz = 2; ld = 1; sgn = 1; end
         EXE_LHU_OP: begin sz = 2; ld = 1; end
         EXE_LW_OP:  begin sz = 4; ld = 1; end
         EXE_SB_OP:  begin sz = 1; st = 1; end
         EXE_SH_OP:  begin sz = 2; st = 1; end
         EXE_SW_OP:  begin sz = 4; st = 1; end
         default:    sz = 0;
      endcase
      off = int'(in.addr[1:0]);
      mis = (sz == 2 && off % 2 != 0) || (sz == 4 && off != 0);
      if (sz != 0 && !mis) begin
         bt.we    = st;
         bt.addr  = in.addr - 32'(off);
         bt.sel   = (sz == 1) ? 4'(1 << (3 - off)) : (sz == 2) ? ((off < 2) ? 4'b1100 : 4'b0011) : 4'hF;
         bt.wdata = !st ? 32'h0 : (sz == 1) ? (in.sdata & 32'hFF) * 32'h0101_0101 :
                    (sz == 2) ? (in.sdata & 32'hFFFF) * 32'h0001_0001 : in.sdata;
         bt.delay = in.delay;
         bus_q.push_back(bt);
         stall_exp += in.delay;
         word = memf(bt.addr);
         if (sz == 1) begin
            val = (word >> (8 * (3 - off))) & 32'hFF;
            if (sgn && val >= 32'd128) val = val - 32'd256;
         end else if (sz == 2) begin
            val = (word >> (16 * (1 - off / 2))) & 32'hFFFF;
            if (sgn && val >= 32'h8000) val = val - 32'h1_0000;
         end else begin
            val = word;
         end
      end
      ev.wreg    = in.wreg && !st && !mis;
      ev.wd      = ev.wreg ? in.wd : 5'd0;
      ev.wdata   = !ev.wreg ? 32'h0 : (ld ? val : in.wdata);
      ev.whilo   = in.whilo;
      ev.hi      = in.whilo ? in.hi : 32'h0;
      ev.lo      = in.whilo ? in.lo : 32'h0;
      ev.mis     = mis;
      ev.badaddr = mis ? in.addr : 32'h0;
      if (ev.wreg || ev.whilo || ev.mis) ev_q.push_back(ev);
   endtask

   task automatic drive(input instr_t in);
      ex_aluop_i = in.aluop; ex_wd_i = in.wd; ex_wreg_i = in.wreg; ex_wdata_i = in.wdata;
      ex_hi_i = in.hi; ex_lo_i = in.lo; ex_whilo_i = in.whilo;
      ex_mem_addr_i = in.addr; ex_store_data_i = in.sdata;
   endtask

   // Called at a falling edge; returns at the falling edge after the op is captured.
   task automatic issue(input instr_t in);
      bit st;
      predict(in);
      drive(in);
      st = 1'b1;
      for (int n = 0; n < 50 && st; n++) begin
         #4;
         st = stallreq_o;
         @(posedge clk);
         if (!st) s_model = in;
         @(negedge clk);
      end
      if (st) begin
         total++; bad++;
         $display("FAIL issue_timeout: op=%h still stalled after 50 cycles", in.aluop);
      end
   endtask

   task automatic check_zero(input string name);
      logic [199:0] act;
      act = {dbus_req_o, dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o, stallreq_o,
             fwd_whilo_o, fwd_hi_o, fwd_lo_o, wb_wd_o, wb_wreg_o, wb_wdata_o, wb_whilo_o,
             misalign_o, badaddr_o};
      total++;
      if (act != '0 || wb_hi_o != 32'h0 || wb_lo_o != 32'h0) begin
         bad++;
         $display("FAIL %s: outputs=%h hi=%h lo=%h, required all zero", name, act, wb_hi_o, wb_lo_o);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Bus responder: checks each new request and acks after the planned delay.
   initial begin : responder
      bus_t cur;
      bit   busy;
      int   cnt;
      busy = 1'b0; cnt = 0;
      dbus_ack_i = 1'b0; dbus_rdata_i = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0; dbus_ack_i = 1'b0;
            continue;
         end
         if (dbus_ack_i) begin
            dbus_ack_i = 1'b0; busy = 1'b0;
         end
         dbus_rdata_i = $urandom;
         if (dbus_req_o && !busy) begin
            total++;
            if (bus_q.size() == 0) begin
               bad++;
               $display("FAIL bus_req: unexpected request addr=%h sel=%h", dbus_addr_o, dbus_sel_o);
               cnt = 0;
            end else begin
               cur = bus_q.pop_front();
               cnt = cur.delay;
               if ({dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_we_o ? dbus_wdata_o : 32'h0} !=
                   {cur.we, cur.addr, cur.sel, cur.wdata}) begin
                  bad++;
                  $display("FAIL bus_req: got we=%b addr=%h sel=%h wdata=%h, required we=%b addr=%h sel=%h wdata=%h",
                           dbus_we_o, dbus_addr_o, dbus_sel_o, dbus_wdata_o,
                           cur.we, cur.addr, cur.sel, cur.wdata);
               end
            end
            busy = 1'b1;
         end
         if (busy) begin
            if (cnt == 0) begin
               dbus_ack_i = 1'b1;
               dbus_rdata_i = memf(dbus_addr_o);
            end else begin
               cnt--;
            end
         end
      end
   end

   initial begin : stall_counter
      forever begin
         @(negedge clk);
         #4;
         if (checking && stallreq_o) stall_cnt++;
      end
   end

   // Monitor: forwarding every cycle, write-back whenever the DUT retires something.
   initial begin : monitor
      ev_t act, exp;
      forever begin
         @(negedge clk);
         if (checking) begin
            total++;
            if ({fwd_whilo_o, fwd_whilo_o ? {fwd_hi_o, fwd_lo_o} : 64'h0} !=
                {s_model.whilo, s_model.whilo ? {s_model.hi, s_model.lo} : 64'h0}) begin
               bad++;
               $display("FAIL fwd_hilo: got whilo=%b hi=%h lo=%h, required whilo=%b hi=%h lo=%h",
                        fwd_whilo_o, fwd_hi_o, fwd_lo_o, s_model.whilo, s_model.hi, s_model.lo);
            end
            if (wb_wreg_o || wb_whilo_o || misalign_o) begin
               act.wreg    = wb_wreg_o;
               act.wd      = wb_wreg_o ? wb_wd_o : 5'd0;
               act.wdata   = wb_wreg_o ? wb_wdata_o : 32'h0;
               act.whilo   = wb_whilo_o;
               act.hi      = wb_whilo_o ? wb_hi_o : 32'h0;
               act.lo      = wb_whilo_o ? wb_lo_o : 32'h0;
               act.mis     = misalign_o;
               act.badaddr = misalign_o ? badaddr_o : 32'h0;
               total++;
               if (ev_q.size() == 0) begin
                  bad++;
                  $display("FAIL wb_event: unexpected write-back %h", act);
               end else begin
                  exp = ev_q.pop_front();
                  if (act != exp) begin
                     bad++;
                     $display("FAIL wb_event: got %h, required %h", act, exp);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      instr_t nop, r;
      logic [7:0] ops [12];
      int k;
      ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP,
              EXE_SH_OP, EXE_SW_OP, OP_OR, OP_MTHI, OP_BOGUS, OP_NOP};
      nop = mk(OP_NOP, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 0);
      s_model = nop;
      drive(nop);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;
      checking = 1'b1;

      mem_over[32'h100] = 32'h0000_0080;
      issue(mk(OP_OR,      5'd3,  1'b1, 32'h0000_F0F0, 1'b0, 32'h0,  32'h0,   32'h0,         0));
      issue(mk(EXE_SW_OP,  5'd7,  1'b1, 32'h1111_1111, 1'b0, 32'h0,  32'h100, 32'hDEAD_BEEF, 2));
      issue(mk(EXE_LB_OP,  5'd4,  1'b1, 32'h0,         1'b0, 32'h0,  32'h103, 32'h0,         0));
      issue(mk(EXE_LBU_OP, 5'd5,  1'b1, 32'h0,         1'b0, 32'h0,  32'h103, 32'h0,         0));
      issue(mk(EXE_SH_OP,  5'd0,  1'b0, 32'h0,         1'b0, 32'h0,  32'h202, 32'h1234_ABCD, 1));
      issue(mk(EXE_LH_OP,  5'd6,  1'b1, 32'h0,         1'b0, 32'h0,  32'h201, 32'h0,         0));
      issue(mk(OP_MTHI,    5'd0,  1'b0, 32'h0,         1'b1, 32'h55, 32'h0,   32'h0,         0));
      issue(mk(EXE_LW_OP,  5'd8,  1'b1, 32'h0,         1'b0, 32'h0,  32'h300, 32'h0,         2));
      issue(mk(EXE_LW_OP,  5'd9,  1'b1, 32'h0,         1'b0, 32'h0,  32'h304, 32'h0,         1));
      issue(mk(EXE_LW_OP,  5'd10, 1'b1, 32'h0,         1'b0, 32'h0,  32'h308, 32'h0,         0));
      repeat (4) issue(nop);
      check_int("directed_stall_cycles", stall_cnt, stall_exp);
      check_int("directed_wb_pending", ev_q.size(), 0);

      // Reset while a load is waiting for its ack.
      issue(mk(EXE_LW_OP, 5'd11, 1'b1, 32'h0, 1'b0, 32'h0, 32'h400, 32'h0, 3));
      drive(nop);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("reset_mid_access");
      @(negedge clk);
      rst = 1'b0;
      ev_q.delete();
      s_model = nop;
      stall_cnt = 0;
      stall_exp = 0;
      issue(mk(EXE_LW_OP, 5'd12, 1'b1, 32'h0, 1'b0, 32'h0, 32'h404, 32'h0, 1));

      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 11);
         r.aluop = ops[k];
         r.wd    = 5'($urandom);
         r.wreg  = 1'($urandom);
         r.wdata = $urandom;
         r.hi    = $urandom;
         r.lo    = $urandom;
         r.whilo = (k >= 8) ? 1'($urandom) : 1'b0;
         r.addr  = $urandom & 32'h0000_0FFF;
         r.sdata = $urandom;
         r.delay = $urandom_range(0, 3);
         issue(r);
      end
      repeat (5) issue(nop);

      check_int("final_stall_cycles", stall_cnt, stall_exp);
      check_int("final_wb_pending", ev_q.size(), 0);
      check_int("final_bus_pending", bus_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
